// File: rtl/bitwise_arbiter16_pkg.sv
// Shared definitions for bitwise_arbiter16: opcode values, FSM state encoding
// and the datapath width of the bitwise unit.
package bitwise_arbiter16_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] OP_NOT = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/bitwise_arbiter16_bitwise16.sv
// bitwise16: purely combinational 16-lane NOT/AND/OR/XOR unit.
// Build option: BITWISE_ARBITER16_XOR_EN builds the XOR lanes. Without it,
// opcode 3 yields zero data with err set, and no XOR gates are built.
module bitwise16
  import bitwise_arbiter16_pkg::*;
(
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              err_o
);

  logic [DATA_W-1:0] not_w;
  logic [DATA_W-1:0] and_w;
  logic [DATA_W-1:0] or_w;

  assign not_w = ~a_i;
  assign and_w = a_i & b_i;
  assign or_w  = a_i | b_i;

  // Select the lane result for the requested opcode.
  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (op_i)
      OP_NOT: result_o = not_w;
      OP_AND: result_o = and_w;
      OP_OR:  result_o = or_w;
      default: begin
`ifdef BITWISE_ARBITER16_XOR_EN
        result_o = a_i ^ b_i;
`else
        err_o    = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/bitwise_arbiter16.sv
// bitwise_arbiter16: round-robin arbiter sharing one bitwise16 unit between
// two requesters, with a single registered, backpressurable response slot.
// Build option: BITWISE_ARBITER16_XOR_EN (enables XOR in bitwise16).
//
// state    | meaning
// ST_EMPTY | response register holds nothing
// ST_FULL  | response register holds a result awaiting rsp_ready
module bitwise_arbiter16
  import bitwise_arbiter16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_err
);

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              id_q, id_d;
  logic              err_q, err_d;

  logic              space_free;
  logic              grant0, grant1, accept;
  logic [1:0]        mux_op;
  logic [WIDTH-1:0]  mux_a, mux_b;
  logic [WIDTH-1:0]  unit_result;
  logic              unit_err;

  // A slot is free when empty or when the held result drains this cycle.
  assign space_free = (state_q == ST_EMPTY) || rsp_ready;

  // Lone requester wins; on contention prio_q picks the winner.
  assign grant0 = space_free && req0_valid && (!req1_valid || !prio_q);
  assign grant1 = space_free && req1_valid && (!req0_valid ||  prio_q);
  assign accept = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign mux_op = grant1 ? req1_op : req0_op;
  assign mux_a  = grant1 ? req1_a  : req0_a;
  assign mux_b  = grant1 ? req1_b  : req0_b;

  bitwise16 u_bitwise16 (
    .op_i     (mux_op),
    .a_i      (mux_a),
    .b_i      (mux_b),
    .result_o (unit_result),
    .err_o    (unit_err)
  );

  // Next-state for the response slot and the round-robin pointer.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    data_d  = data_q;
    id_d    = id_q;
    err_d   = err_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (accept)         state_d = ST_FULL;
        else if (rsp_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (accept) begin
      data_d = unit_result;
      id_d   = grant1;
      err_d  = unit_err;
      prio_d = grant0;
    end
  end

  // FSM and response registers; reset discards any held result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      prio_q  <= 1'b0;
      data_q  <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      data_q  <= data_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_bitwise_arbiter16.sv
// Self-checking bench for bitwise_arbiter16: directed scenarios plus a
// randomized run against a lane-by-lane behavioural model.
module tb_bitwise_arbiter16;

`ifdef BITWISE_ARBITER16_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [1:0]  req0_op;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [1:0]  req1_op;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_id, rsp_err;

  int n_pass;
  int n_total;

  bitwise_arbiter16 #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      case (op)
        2'd0:    r[i] = (a[i] == 1'b0);
        2'd1:    r[i] = (a[i] == 1'b1) && (b[i] == 1'b1);
        2'd2:    r[i] = (a[i] == 1'b1) || (b[i] == 1'b1);
        default: r[i] = XOR_EN ? (a[i] != b[i]) : 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic ref_err(input logic [1:0] op);
    return (op == 2'd3) && !XOR_EN;
  endfunction

  task automatic idle_inputs();
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp_ready  = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #3;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (rsp_data !== 16'h0000) $display("FAIL reset_data: got %h want 0000", rsp_data); else n_pass++;
    n_total++; if (rsp_id !== 1'b0 || rsp_err !== 1'b0)
      $display("FAIL reset_id_err: got id=%b err=%b want 0 0", rsp_id, rsp_err); else n_pass++;
    n_total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
      $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 1; req0_valid = 1; req0_op = 2'd0; req0_a = 16'h00FF; req0_b = 16'h1234;
    #1;
    n_total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready); else n_pass++;
    @(posedge clk); #1;
    req0_valid = 0;
    n_total++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hFF00 || rsp_id !== 1'b0 || rsp_err !== 1'b0)
      $display("FAIL single_rsp: got v=%b d=%h id=%b e=%b want 1 ff00 0 0",
               rsp_valid, rsp_data, rsp_id, rsp_err); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_contention();
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_op = 2'd1; req0_a = 16'hF0F0; req0_b = 16'h3C3C;
    req1_valid = 1; req1_op = 2'd2; req1_a = 16'h000F; req1_b = 16'h0F00;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_total++; if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1))
        $display("FAIL contention_grant%0d: got %b%b want %b%b", k, req0_ready, req1_ready,
                 (k % 2 == 0), (k % 2 == 1)); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (rsp_valid !== 1'b1 || rsp_id !== (k % 2 == 1) ||
                     rsp_data !== ((k % 2 == 0) ? 16'h3030 : 16'h0F0F))
        $display("FAIL contention_rsp%0d: got v=%b d=%h id=%b", k, rsp_valid, rsp_data, rsp_id);
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 0;
    req0_valid = 1; req0_op = 2'd1; req0_a = 16'hF0F0; req0_b = 16'h3C3C;
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 1; req1_op = 2'd2; req1_a = 16'h000F; req1_b = 16'h0F00;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
        $display("FAIL bp_ready%0d: got %b%b want 00", k, req0_ready, req1_ready); else n_pass++;
      n_total++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h3030 || rsp_id !== 1'b0)
        $display("FAIL bp_hold%0d: got v=%b d=%h id=%b want 1 3030 0", k, rsp_valid, rsp_data, rsp_id);
      else n_pass++;
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    #1;
    n_total++; if (req1_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", req1_ready); else n_pass++;
    @(posedge clk); #1;
    req1_valid = 0;
    n_total++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0F0F || rsp_id !== 1'b1)
      $display("FAIL bp_no_bubble: got v=%b d=%h id=%b want 1 0f0f 1", rsp_valid, rsp_data, rsp_id);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_xor();
    do_reset();
    rsp_ready = 1;
    req1_valid = 1; req1_op = 2'd3; req1_a = 16'hAAAA; req1_b = 16'hFFFF;
    @(posedge clk); #1;
    req1_valid = 0;
    n_total++; if (rsp_valid !== 1'b1 || rsp_data !== (XOR_EN ? 16'h5555 : 16'h0000) ||
                   rsp_err !== !XOR_EN || rsp_id !== 1'b1)
      $display("FAIL xor_rsp: got v=%b d=%h e=%b id=%b want d=%h e=%b id=1", rsp_valid, rsp_data,
               rsp_err, rsp_id, (XOR_EN ? 16'h5555 : 16'h0000), !XOR_EN);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 0;
    req0_valid = 1; req0_op = 2'd2; req0_a = 16'h1111; req0_b = 16'h2222;
    @(posedge clk); #1;
    req0_valid = 0;
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL rstmid_full: got %b want 1", rsp_valid); else n_pass++;
    reset = 1;
    #1;
    n_total++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000)
      $display("FAIL rstmid_clear: got v=%b d=%h want 0 0000", rsp_valid, rsp_data); else n_pass++;
    @(posedge clk); #1;
    reset = 0;
    rsp_ready = 1;
    req0_valid = 1; req1_valid = 1;
    #1;
    n_total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL rstmid_prio: got %b%b want 10", req0_ready, req1_ready); else n_pass++;
    idle_inputs();
    #1;
  endtask

  task automatic test_operand_change();
    do_reset();
    rsp_ready = 0;
    req0_valid = 1; req0_op = 2'd1; req0_a = 16'h1234; req0_b = 16'hFF00;
    @(posedge clk); #1;
    req0_a = 16'hFFFF; req0_b = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_total++; if (rsp_data !== 16'h1200)
        $display("FAIL opchange_hold%0d: got %h want 1200", k, rsp_data); else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic        m_valid, m_id, m_err, m_prio;
    logic [15:0] m_data;
    logic        acc, pick;
    logic [1:0]  s_op;
    logic [15:0] s_a, s_b;
    do_reset();
    m_valid = 0; m_id = 0; m_err = 0; m_prio = 0; m_data = 0;
    for (int c = 0; c < 400; c++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_op = 2'($urandom_range(0, 3)); req0_a = 16'($urandom); req0_b = 16'($urandom);
      req1_op = 2'($urandom_range(0, 3)); req1_a = 16'($urandom); req1_b = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc  = (!m_valid || rsp_ready) && (req0_valid || req1_valid);
      pick = (req0_valid && req1_valid) ? m_prio : req1_valid;
      s_op = pick ? req1_op : req0_op;
      s_a  = pick ? req1_a  : req0_a;
      s_b  = pick ? req1_b  : req0_b;
      n_total++; if (req0_ready !== (acc && !pick) || req1_ready !== (acc && pick))
        $display("FAIL rand_ready c%0d: got %b%b want %b%b", c, req0_ready, req1_ready,
                 (acc && !pick), (acc && pick)); else n_pass++;
      @(posedge clk); #1;
      if (acc) begin
        m_valid = 1; m_data = ref_result(s_op, s_a, s_b); m_err = ref_err(s_op);
        m_id = pick; m_prio = !pick;
      end else if (rsp_ready) begin
        m_valid = 0;
      end
      n_total++; if (rsp_valid !== m_valid)
        $display("FAIL rand_valid c%0d: got %b want %b", c, rsp_valid, m_valid); else n_pass++;
      if (m_valid) begin
        n_total++; if (rsp_data !== m_data || rsp_id !== m_id || rsp_err !== m_err)
          $display("FAIL rand_rsp c%0d: got d=%h id=%b e=%b want d=%h id=%b e=%b",
                   c, rsp_data, rsp_id, rsp_err, m_data, m_id, m_err);
        else n_pass++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_xor();
    test_reset_mid();
    test_operand_change();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
